// File: rtl/ucsbece154b_branch_resolve_if.sv
// Bus between the branch-resolve block and its fetch / execute / predictor neighbours.
// The master side drives fetch-time prediction and execute-time outcome; the slave
// side (the resolver) returns next PC, mispredict flag, predictor updates and counters.
interface ucsbece154b_branch_resolve_if #(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5
);
   localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

   logic [31:0]             pcF_i;
   logic                    BranchTakenF_i;
   logic [31:0]             BTBtargetF_i;
   logic [NUM_GHR_BITS-1:0] PHTaddrF_i;
   logic                    StallD_i;
   logic                    FlushD_i;
   logic                    FlushE_i;
   logic [6:0]              opE_i;
   logic                    TakenE_i;
   logic [31:0]             PCTargetE_i;

   logic [31:0]             PCnextF_o;
   logic                    MispredictE_o;
   logic                    PHTwe_o;
   logic                    PHTincrement_o;
   logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
   logic                    GHRwe_o;
   logic                    GHRtaken_o;
   logic                    GHRreset_o;
   logic                    BTBwe_o;
   logic [BTB_IDX_W-1:0]    BTBwriteaddress_o;
   logic [31:0]             BTBwritedata_o;
   logic [31:0]             branch_count_o;
   logic [31:0]             mispredict_count_o;

   modport master (
      output pcF_i, BranchTakenF_i, BTBtargetF_i, PHTaddrF_i, StallD_i, FlushD_i, FlushE_i,
             opE_i, TakenE_i, PCTargetE_i,
      input  PCnextF_o, MispredictE_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRwe_o,
             GHRtaken_o, GHRreset_o, BTBwe_o, BTBwriteaddress_o, BTBwritedata_o,
             branch_count_o, mispredict_count_o
   );

   modport slave (
      input  pcF_i, BranchTakenF_i, BTBtargetF_i, PHTaddrF_i, StallD_i, FlushD_i, FlushE_i,
             opE_i, TakenE_i, PCTargetE_i,
      output PCnextF_o, MispredictE_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRwe_o,
             GHRtaken_o, GHRreset_o, BTBwe_o, BTBwriteaddress_o, BTBwritedata_o,
             branch_count_o, mispredict_count_o
   );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Branch resolver: carries each fetch's prediction through D and E, compares it with
// the real outcome in E, redirects fetch on a mispredict and drives PHT/GHR/BTB updates.
module ucsbece154b_branch_resolve #(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5
) (
   input  logic                       clk,
   input  logic                       reset_i,
   ucsbece154b_branch_resolve_if.slave bus
);
   localparam int         BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic                    valid;
      logic [31:0]             pc;
      logic                    pred_taken;
      logic [31:0]             pred_target;
      logic [NUM_GHR_BITS-1:0] pht_addr;
   } stage_t;

   stage_t      stage_d, stage_e;
   logic        is_branch, is_jump, ctrl_e, actual_taken, target_wrong, mispredict;
   logic [31:0] branch_count_q, mispredict_count_q;

   // Classify the op in E and decide whether its prediction was wrong.
   always_comb begin
      is_branch    = stage_e.valid && (bus.opE_i == OP_BRANCH);
      is_jump      = stage_e.valid && ((bus.opE_i == OP_JAL) || (bus.opE_i == OP_JALR));
      ctrl_e       = is_branch || is_jump;
      actual_taken = is_jump || (is_branch && bus.TakenE_i);
      target_wrong = (stage_e.pred_target != bus.PCTargetE_i);
      mispredict   = ctrl_e && ((actual_taken != stage_e.pred_taken) ||
                                (actual_taken && target_wrong));
   end

   assign bus.MispredictE_o      = mispredict;
   assign bus.PCnextF_o          = mispredict ? (actual_taken ? bus.PCTargetE_i : stage_e.pc + 32'd4)
                                              : (bus.BranchTakenF_i ? bus.BTBtargetF_i : bus.pcF_i + 32'd4);
   assign bus.PHTwe_o            = is_branch && !reset_i;
   assign bus.GHRwe_o            = is_branch && !reset_i;
   assign bus.PHTincrement_o     = bus.TakenE_i;
   assign bus.GHRtaken_o         = bus.TakenE_i;
   assign bus.PHTwriteaddress_o  = stage_e.pht_addr;
   assign bus.GHRreset_o         = reset_i;
   assign bus.BTBwe_o            = ctrl_e && actual_taken && (!stage_e.pred_taken || target_wrong) && !reset_i;
   assign bus.BTBwriteaddress_o  = stage_e.pc[BTB_IDX_W+1:2];
   assign bus.BTBwritedata_o     = bus.PCTargetE_i;
   assign bus.branch_count_o     = branch_count_q;
   assign bus.mispredict_count_o = mispredict_count_q;

   // F->D and D->E prediction registers; a mispredict kills both wrong-path entries
   // and takes priority over a D stall.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         stage_d <= '0;
         stage_e <= '0;
      end else begin
         if (bus.FlushD_i || mispredict)
            stage_d <= '0;
         else if (!bus.StallD_i)
            stage_d <= stage_t'{valid: 1'b1, pc: bus.pcF_i, pred_taken: bus.BranchTakenF_i,
                                pred_target: bus.BTBtargetF_i, pht_addr: bus.PHTaddrF_i};
         if (bus.FlushE_i || mispredict)
            stage_e <= '0;
         else
            stage_e <= stage_d;
      end
   end

   // Saturating performance counters for resolved control ops and mispredicts.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         if (ctrl_e && (branch_count_q != '1))
            branch_count_q <= branch_count_q + 32'd1;
         if (mispredict && (mispredict_count_q != '1))
            mispredict_count_q <= mispredict_count_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Scoreboard bench for the branch resolver: a driver issues one cycle of stimulus at a
// time and queues the expected outputs from a behavioural model; a monitor compares.
module tb_ucsbece154b_branch_resolve;
   localparam int         N   = 32;
   localparam int         G   = 5;
   localparam int         IW  = $clog2(N);
   localparam logic [6:0] B   = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] JR  = 7'b1100111;
   localparam logic [6:0] ALU = 7'b0110011;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(N), .NUM_GHR_BITS(G)) bus ();
   ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(N), .NUM_GHR_BITS(G)) dut (
      .clk(clk), .reset_i(reset_i), .bus(bus)
   );

   typedef struct {
      logic          v;
      logic [31:0]   pc;
      logic          pt;
      logic [31:0]   ptg;
      logic [G-1:0]  pa;
   } ent_t;

   typedef struct {
      logic [31:0]  pcnext;
      logic         mis, phtwe, inc, ghrwe, ghrtaken, ghrreset, btbwe;
      logic [G-1:0] pa;
      logic [IW-1:0] ba;
      logic [31:0]  bd, bc, mc;
   } exp_t;

   ent_t        m_d, m_e;
   logic [31:0] m_bc, m_mc;
   exp_t        q[$];
   exp_t        mx;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; expected outputs come from the model state for this cycle.
   task automatic step(input logic rst, input logic [31:0] pcf, input logic btf,
                       input logic [31:0] tgtf, input logic [G-1:0] paf,
                       input logic stall, input logic fd, input logic fe,
                       input logic [6:0] op, input logic tk, input logic [31:0] tgte);
      exp_t x;
      logic is_ctrl, is_br, act, mis;
      @(posedge clk); #1;
      reset_i = rst;
      bus.pcF_i = pcf; bus.BranchTakenF_i = btf; bus.BTBtargetF_i = tgtf; bus.PHTaddrF_i = paf;
      bus.StallD_i = stall; bus.FlushD_i = fd; bus.FlushE_i = fe;
      bus.opE_i = op; bus.TakenE_i = tk; bus.PCTargetE_i = tgte;

      is_br = m_e.v && (op == B);
      case (op)
         JAL, JR: begin is_ctrl = m_e.v; act = 1'b1; end
         B:       begin is_ctrl = m_e.v; act = tk;   end
         default: begin is_ctrl = 1'b0;  act = 1'b0; end
      endcase
      mis = is_ctrl && ((act != m_e.pt) || (act && (m_e.ptg != tgte)));

      x.pcnext   = mis ? (act ? tgte : m_e.pc + 32'd4) : (btf ? tgtf : pcf + 32'd4);
      x.mis      = mis;
      x.phtwe    = is_br && !rst;
      x.ghrwe    = is_br && !rst;
      x.inc      = tk;
      x.ghrtaken = tk;
      x.ghrreset = rst;
      x.btbwe    = !rst && is_ctrl && act && (!m_e.pt || (m_e.ptg != tgte));
      x.pa       = m_e.pa;
      x.ba       = IW'((m_e.pc >> 2) % N);
      x.bd       = tgte;
      x.bc       = m_bc;
      x.mc       = m_mc;
      q.push_back(x);

      if (rst) begin
         m_d = '{default: '0}; m_e = '{default: '0}; m_bc = '0; m_mc = '0;
      end else begin
         if (is_ctrl && (m_bc != 32'hFFFF_FFFF)) m_bc = m_bc + 32'd1;
         if (mis && (m_mc != 32'hFFFF_FFFF))     m_mc = m_mc + 32'd1;
         if (fe || mis) m_e = '{default: '0};
         else           m_e = m_d;
         if (fd || mis)   m_d = '{default: '0};
         else if (!stall) m_d = '{v: 1'b1, pc: pcf, pt: btf, ptg: tgtf, pa: paf};
      end
   endtask

   // Monitor: each cycle the DUT presents a response, compare against the queued one.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            mx = q.pop_front();
            chk ("PCnextF",      bus.PCnextF_o,          mx.pcnext);
            chk1("Mispredict",   bus.MispredictE_o,      mx.mis);
            chk1("PHTwe",        bus.PHTwe_o,            mx.phtwe);
            chk1("GHRwe",        bus.GHRwe_o,            mx.ghrwe);
            chk1("GHRreset",     bus.GHRreset_o,         mx.ghrreset);
            chk1("BTBwe",        bus.BTBwe_o,            mx.btbwe);
            chk ("BTBwritedata", bus.BTBwritedata_o,     mx.bd);
            chk ("branch_count", bus.branch_count_o,     mx.bc);
            chk ("mispr_count",  bus.mispredict_count_o, mx.mc);
            if (mx.phtwe) begin
               chk1("PHTincrement", bus.PHTincrement_o, mx.inc);
               chk1("GHRtaken",     bus.GHRtaken_o,     mx.ghrtaken);
               chk ("PHTwaddr",     32'(bus.PHTwriteaddress_o), 32'(mx.pa));
            end
            if (mx.btbwe)
               chk("BTBwaddr", 32'(bus.BTBwriteaddress_o), 32'(mx.ba));
         end
      end
   end

   initial begin
      logic [6:0]  rop;
      logic [31:0] rtg;
      reset_i = 1'b1;
      bus.pcF_i = '0; bus.BranchTakenF_i = 1'b0; bus.BTBtargetF_i = '0; bus.PHTaddrF_i = '0;
      bus.StallD_i = 1'b0; bus.FlushD_i = 1'b0; bus.FlushE_i = 1'b0;
      bus.opE_i = ALU; bus.TakenE_i = 1'b0; bus.PCTargetE_i = '0;
      m_d = '{default: '0}; m_e = '{default: '0}; m_bc = '0; m_mc = '0;

      step(1, 0, 0, 0, 0, 0, 0, 0, ALU, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, ALU, 0, 0);
      // beq @0x100 predicted not-taken, actually taken to 0x80
      step(0, 32'h100, 0, 32'h0,   5'h3, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h104, 1, 32'h200, 5'h4, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h104, 1, 32'h200, 5'h4, 0, 0, 0, B,   1, 32'h80);
      // beq @0x104 predicted taken to 0x200, actually not taken
      step(0, 32'h104, 1, 32'h200, 5'h4, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h10,  1, 32'h40,  5'h5, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h10,  1, 32'h40,  5'h5, 0, 0, 0, B,   0, 32'h200);
      // jal @0x10 correctly predicted
      step(0, 32'h10,  1, 32'h40,  5'h5, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h14,  0, 32'h0,   5'h6, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h18,  0, 32'h0,   5'h7, 0, 0, 0, JAL, 0, 32'h40);
      // mispredict in E while D is stalled: stalled entry must not survive
      step(0, 32'h300, 0, 32'h0,   5'h8, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h304, 0, 32'h0,   5'h9, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h308, 0, 32'h0,   5'hA, 1, 0, 0, B,   1, 32'h500);
      step(0, 32'h30C, 0, 32'h0,   5'hB, 0, 0, 0, B,   1, 32'h600);
      step(0, 32'h310, 0, 32'h0,   5'hC, 0, 0, 0, B,   1, 32'h700);
      // fetch PC wrap on +4
      step(0, 32'hFFFF_FFFC, 0, 32'h0, 5'h1, 0, 0, 0, ALU, 0, 0);
      // reset with a branch in E
      step(0, 32'h400, 0, 32'h0,   5'h2, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h404, 0, 32'h0,   5'h2, 0, 0, 0, ALU, 0, 0);
      step(1, 32'h408, 0, 32'h0,   5'h2, 0, 0, 0, B,   1, 32'h900);
      step(0, 32'h40C, 0, 32'h0,   5'h2, 0, 0, 0, B,   1, 32'h900);
      step(0, 32'h410, 0, 32'h0,   5'h2, 0, 0, 0, B,   1, 32'h900);
      // branch_count saturation
      step(0, 32'h500, 1, 32'h600, 5'h3, 0, 0, 0, ALU, 0, 0);
      step(0, 32'h504, 1, 32'h700, 5'h3, 0, 0, 0, ALU, 0, 0);
      @(negedge clk); #1;
      force dut.branch_count_q = 32'hFFFF_FFFF;
      m_bc = 32'hFFFF_FFFF;
      step(0, 32'h508, 0, 32'h0,   5'h3, 0, 0, 0, B,   1, 32'h600);
      release dut.branch_count_q;
      step(0, 32'h50C, 0, 32'h0,   5'h3, 0, 0, 0, JAL, 0, 32'h700);
      step(0, 32'h510, 0, 32'h0,   5'h3, 0, 0, 0, B,   0, 32'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0, ALU, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       rop = B;
            1:       rop = JAL;
            2:       rop = JR;
            default: rop = ALU;
         endcase
         rtg = ($urandom_range(0, 1) == 1) ? m_e.ptg : ($urandom() & 32'hFFFF_FFFC);
         step($urandom_range(0, 99) < 2,
              $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
              $urandom() & 32'hFFFF_FFFC, G'($urandom()),
              $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1,
              rop, 1'($urandom_range(0, 1)), rtg);
      end

      repeat (3) @(negedge clk);
      #1;
      chk("queue_drain", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
